fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the single-issue MIPS pipeline. Owns the program counter, drives the address of the combinational instruction memory, and captures the returned word into the IF/ID pipeline register. Resolves `j`/`jal` in-stage with no bubble, and accepts stall and redirect requests from later stages. Detects misaligned redirect targets and parks in a fault state.

## Interface
- `RESET_PC`, 32'd40, PC value loaded on reset (word index 10 of instruction memory).
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `stall`  in  1  hazard unit: hold PC, IF/ID and counter this cycle.
- `redirect_valid`  in  1  later stage (taken branch, `jr`) overrides the next PC and squashes IF/ID.
- `redirect_pc`  in  32  redirect target byte address.
- `imem_addr`  out  32  byte address to instruction memory; equals PC (combinational).
- `imem_instr`  in  32  instruction word returned for `imem_addr`, same cycle.
- `if_id_instr`  out  32  registered instruction.
- `if_id_pc_plus4`  out  32  registered PC+4 of that instruction (jal link value).
- `if_id_valid`  out  1  IF/ID holds a real instruction; 0 = bubble.
- `fault`  out  1  sticky: misaligned redirect seen.
- `fault_pc`  out  32  offending redirect address, valid while `fault`=1.
- `fetch_count`  out  32  number of instructions delivered with `if_id_valid`=1.

## Operation
- States: RUN, FAULT. Reset enters RUN.
- Reset values: PC=RESET_PC, `if_id_instr`=0, `if_id_pc_plus4`=0, `if_id_valid`=0, `fault`=0, `fault_pc`=0, `fetch_count`=0.
- `pc_plus4` = PC + 32'd4, modulo 2^32 (0xFFFFFFFC wraps to 0).
- Fetch-stage jump: when `imem_instr[31:26]` is 6'b000010 or 6'b000011, `jump_target` = {pc_plus4[31:28], imem_instr[25:0], 2'b00}. The jump word is still delivered to IF/ID as valid. Decode must not redirect again for `j`/`jal`.
- RUN, per rising edge, first matching rule applies:
  1. `redirect_valid`=1, `redirect_pc[1:0]`≠0: go to FAULT. `fault`<=1, `fault_pc`<=`redirect_pc`, `if_id_valid`<=0. PC holds.
  2. `redirect_valid`=1, aligned: PC<=`redirect_pc`, `if_id_valid`<=0, count holds. This rule applies even when `stall`=1.
  3. `stall`=1: PC, IF/ID and count all hold.
  4. Otherwise: IF/ID<={`imem_instr`, `pc_plus4`}, `if_id_valid`<=1, count+=1. PC<=`jump_target` if the word is a jump, else `pc_plus4`.
- FAULT: PC and `fault_pc` are frozen. `if_id_valid`=0. All inputs are ignored. Only reset leaves this state.
- `fetch_count` wraps from 0xFFFFFFFF to 0.

## Timing
- Instruction memory is combinational, so fetch takes 1 cycle. The word at PC appears on `if_id_*` after the next rising edge.
- Taken redirect costs exactly one bubble: the edge that applies the redirect writes `if_id_valid`=0. The target instruction appears in IF/ID one edge later.
- Fetch-stage `j`/`jal` costs 0 bubbles: the jump word and its target occupy consecutive IF/ID cycles.
- Reset is asynchronous. Asserting it mid-cycle clears all state immediately, including FAULT.
- The first rising edge after reset deasserts loads the word at RESET_PC into IF/ID.
- `imem_addr` is stable for a full cycle after each edge, and held while stalled.

## Test plan
- Straight-line fetch: memory holds `addi` words at 40, 44, 48. Release reset, then 3 edges -> `if_id_pc_plus4` = 44, 48, 52; `if_id_valid`=1; `fetch_count`=3.
- In-stage jump: word 0x08000008 at 52 -> IF/ID shows 0x08000008 with `pc_plus4`=56. `imem_addr` becomes 32 on the same edge, and the next IF/ID has `pc_plus4`=36 with no bubble.
- Stall: `stall`=1 for 2 cycles mid-stream -> `imem_addr`, `if_id_*` and `fetch_count` are unchanged for both cycles. Fetch resumes in order afterwards.
- Redirect over stall: `stall`=1 and `redirect_valid`=1 with `redirect_pc`=0x100 -> next edge PC=0x100 and `if_id_valid`=0. The following edge delivers `pc_plus4`=0x104.
- Misaligned redirect: `redirect_pc`=0x102 -> `fault`=1, `fault_pc`=0x102, `if_id_valid` stays 0, PC frozen for 10 cycles despite toggling `stall`/`redirect_valid`. Then assert reset mid-cycle -> `fault`=0 and PC=40 immediately.
- PC wrap: redirect to 0xFFFFFFFC, no stall -> IF/ID `pc_plus4`=0, then `imem_addr`=0.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, resolves j/jal in-stage, and fills the IF/ID register.
// Misaligned redirect targets park the stage in FAULT until reset.
//
// state | meaning
// RUN   | fetching, honouring redirect/stall
// FAULT | misaligned redirect seen; PC and fault_pc frozen until reset
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'd40
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_instr,
   output logic [31:0] if_id_instr,
   output logic [31:0] if_id_pc_plus4,
   output logic        if_id_valid,
   output logic        fault,
   output logic [31:0] fault_pc,
   output logic [31:0] fetch_count
);

   typedef enum logic {RUN, FAULT} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc4_q, pc4_d;
   logic        valid_q, valid_d;
   logic [31:0] fault_pc_q, fault_pc_d;
   logic [31:0] count_q, count_d;

   logic [31:0] pc_plus4;
   logic [31:0] jump_target;
   logic        is_jump;

   assign pc_plus4    = pc_q + 32'd4;
   assign is_jump     = (imem_instr[31:27] == 5'b00001);
   assign jump_target = {pc_plus4[31:28], imem_instr[25:0], 2'b00};

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      instr_d    = instr_q;
      pc4_d      = pc4_q;
      valid_d    = valid_q;
      fault_pc_d = fault_pc_q;
      count_d    = count_q;
      if (state_q == RUN) begin
         if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
            state_d    = FAULT;
            fault_pc_d = redirect_pc;
            valid_d    = 1'b0;
         end else if (redirect_valid) begin
            // A redirect wins over a stall: the squashed slot must not linger.
            pc_d    = redirect_pc;
            valid_d = 1'b0;
         end else if (!stall) begin
            instr_d = imem_instr;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
            count_d = count_q + 32'd1;
            pc_d    = is_jump ? jump_target : pc_plus4;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= RUN;
         pc_q       <= RESET_PC;
         instr_q    <= '0;
         pc4_q      <= '0;
         valid_q    <= 1'b0;
         fault_pc_q <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         instr_q    <= instr_d;
         pc4_q      <= pc4_d;
         valid_q    <= valid_d;
         fault_pc_q <= fault_pc_d;
         count_q    <= count_d;
      end
   end

   assign imem_addr      = pc_q;
   assign if_id_instr    = instr_q;
   assign if_id_pc_plus4 = pc4_q;
   assign if_id_valid    = valid_q;
   assign fault          = (state_q == FAULT);
   assign fault_pc       = fault_pc_q;
   assign fetch_count    = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios with literal expectations, then random
// stall/redirect traffic, all checked every cycle against a behavioural model.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        stall = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic [31:0] imem_addr;
   logic [31:0] imem_instr;
   logic [31:0] if_id_instr;
   logic [31:0] if_id_pc_plus4;
   logic        if_id_valid;
   logic        fault;
   logic [31:0] fault_pc;
   logic [31:0] fetch_count;

   int checks = 0;
   int errors = 0;
   bit chk_on = 1'b0;

   fetch_stage #(.RESET_PC(32'd40)) dut (
      .clk(clk), .reset(reset), .stall(stall),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem_addr(imem_addr), .imem_instr(imem_instr),
      .if_id_instr(if_id_instr), .if_id_pc_plus4(if_id_pc_plus4),
      .if_id_valid(if_id_valid), .fault(fault), .fault_pc(fault_pc),
      .fetch_count(fetch_count)
   );

   always #5 clk = ~clk;

   // Instruction memory contents: fixed words for the directed part, hashed filler elsewhere.
   function automatic logic [31:0] mem(input logic [31:0] a);
      logic [31:0] h;
      case (a)
         32'd32, 32'd36, 32'd40, 32'd44, 32'd48: return 32'h2008_0000 | a;
         32'd52:         return 32'h0800_0008;
         32'h100:        return 32'h2009_0100;
         32'hFFFF_FFFC:  return 32'h200A_0001;
         default: begin
            h = a * 32'h9E37_79B1;
            if (h[31:29] == 3'b000) return {6'b000011, h[25:0]};
            if (h[31:29] == 3'b001) return {6'b000010, h[25:0]};
            return {6'b001000, h[25:0]};
         end
      endcase
   endfunction

   assign imem_instr = mem(imem_addr);

   // Behavioural model
   logic [31:0] m_pc, m_instr, m_pc4, m_fault_pc, m_count;
   logic        m_valid, m_fault;

   always @(posedge clk or posedge reset) begin
      logic [31:0] w, p4;
      if (reset) begin
         m_pc = 32'd40; m_instr = 0; m_pc4 = 0; m_valid = 0;
         m_fault = 0; m_fault_pc = 0; m_count = 0;
      end else if (!m_fault) begin
         w  = mem(m_pc);
         p4 = m_pc + 32'd4;
         if (redirect_valid && redirect_pc % 4 != 0) begin
            m_fault = 1; m_fault_pc = redirect_pc; m_valid = 0;
         end else if (redirect_valid) begin
            m_pc = redirect_pc; m_valid = 0;
         end else if (!stall) begin
            m_instr = w; m_pc4 = p4; m_valid = 1; m_count = m_count + 1;
            if (w[31:26] == 6'd2 || w[31:26] == 6'd3)
               m_pc = {p4[31:28], w[25:0], 2'b00};
            else
               m_pc = p4;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_on && !reset) begin
         chk("imem_addr", imem_addr, m_pc);
         chk("if_id_instr", if_id_instr, m_instr);
         chk("if_id_pc_plus4", if_id_pc_plus4, m_pc4);
         chk("if_id_valid", {31'd0, if_id_valid}, {31'd0, m_valid});
         chk("fault", {31'd0, fault}, {31'd0, m_fault});
         chk("fault_pc", fault_pc, m_fault_pc);
         chk("fetch_count", fetch_count, m_count);
      end
   end

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      int fault_age;
      #1 reset = 1'b1;
      #20;
      @(negedge clk);
      chk("rst_addr", imem_addr, 32'd40);
      chk("rst_valid", {31'd0, if_id_valid}, 32'd0);
      chk("rst_count", fetch_count, 32'd0);
      reset = 1'b0;
      chk_on = 1'b1;

      step(); chk("seq1_pc4", if_id_pc_plus4, 32'd44);
      step(); chk("seq2_pc4", if_id_pc_plus4, 32'd48);
      step(); chk("seq3_pc4", if_id_pc_plus4, 32'd52);
      chk("seq3_count", fetch_count, 32'd3);
      chk("seq3_valid", {31'd0, if_id_valid}, 32'd1);

      step(); chk("jmp_instr", if_id_instr, 32'h0800_0008);
      chk("jmp_pc4", if_id_pc_plus4, 32'd56);
      chk("jmp_addr", imem_addr, 32'd32);
      step(); chk("jmp_tgt_pc4", if_id_pc_plus4, 32'd36);
      chk("jmp_tgt_valid", {31'd0, if_id_valid}, 32'd1);

      stall = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step();
         chk("stall_addr", imem_addr, 32'd36);
         chk("stall_pc4", if_id_pc_plus4, 32'd36);
         chk("stall_count", fetch_count, 32'd5);
      end
      stall = 1'b0;
      step(); chk("resume_pc4", if_id_pc_plus4, 32'd40);
      chk("resume_count", fetch_count, 32'd6);

      stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h100;
      step(); chk("redir_addr", imem_addr, 32'h100);
      chk("redir_valid", {31'd0, if_id_valid}, 32'd0);
      chk("redir_count", fetch_count, 32'd6);
      stall = 1'b0; redirect_valid = 1'b0;
      step(); chk("redir_tgt_pc4", if_id_pc_plus4, 32'h104);

      redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
      step(); chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
      redirect_valid = 1'b0;
      step(); chk("wrap_pc4", if_id_pc_plus4, 32'd0);
      chk("wrap_addr", imem_addr, 32'd0);

      redirect_valid = 1'b1; redirect_pc = 32'h102;
      step(); chk("flt", {31'd0, fault}, 32'd1);
      chk("flt_pc", fault_pc, 32'h102);
      chk("flt_valid", {31'd0, if_id_valid}, 32'd0);
      for (int i = 0; i < 10; i++) begin
         stall = $urandom_range(0, 1);
         redirect_valid = $urandom_range(0, 1);
         redirect_pc = $urandom & 32'hFFFF_FFFC;
         step();
         chk("flt_frozen_addr", imem_addr, 32'd0);
         chk("flt_frozen_pc", fault_pc, 32'h102);
      end
      stall = 1'b0; redirect_valid = 1'b0;

      #2 reset = 1'b1;
      #1;
      chk("arst_fault", {31'd0, fault}, 32'd0);
      chk("arst_addr", imem_addr, 32'd40);
      chk("arst_count", fetch_count, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      fault_age = 0;
      for (int i = 0; i < 3000; i++) begin
         stall = ($urandom_range(0, 3) == 0);
         redirect_valid = ($urandom_range(0, 9) == 0);
         case ($urandom_range(0, 19))
            0:       redirect_pc = 32'h200 | $urandom_range(1, 3);
            1:       redirect_pc = 32'hFFFF_FFF8;
            default: redirect_pc = $urandom_range(0, 32'hFFFF) & 32'hFFFF_FFFC;
         endcase
         step();
         if (fault) fault_age++;
         if (fault_age > 5) begin
            #2 reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            fault_age = 0;
         end
      end

      chk_on = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
